// File: rtl/reqrsp_xbar_pkg.sv
// Shared definitions for the crossbar request/response tracking logic.
// Holds the source-index width helper and the tracker error codes.
package reqrsp_xbar_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encoding reported through the cluster status register.
  typedef enum logic [1:0] {
    TrkErrNone     = 2'd0,
    TrkErrSpurious = 2'd1,
    TrkErrOverflow = 2'd2
  } tracker_err_e;

endpackage

// File: rtl/fifo_v3.sv
// Generic circular FIFO; one-cycle write-to-read latency unless FALL_THROUGH.
// Push is ignored while full, pop is ignored while empty; no other stalling.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [AddrDepth-1:0] usage_o,
  input  dtype                 data_i,
  input  logic                 push_i,
  output dtype                 data_o,
  input  logic                 pop_i
);

  localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

  logic [AddrDepth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AddrDepth:0]   cnt_q, cnt_d;
  dtype                 mem_q [FifoDepth];
  dtype                 mem_d [FifoDepth];
  logic                 cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign full_o   = (cnt_q == (AddrDepth+1)'(FifoDepth));
  assign empty_o  = cnt_zero & ~(FALL_THROUGH & push_i);
  assign usage_o  = cnt_q[AddrDepth-1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    data_o   = mem_q[rd_ptr_q];

    if (push_i && !full_o) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == AddrDepth'(FifoDepth - 1)) ? '0 : wr_ptr_q + AddrDepth'(1);
      cnt_d    = cnt_q + (AddrDepth+1)'(1);
    end

    if (pop_i && !empty_o) begin
      rd_ptr_d = (rd_ptr_q == AddrDepth'(FifoDepth - 1)) ? '0 : rd_ptr_q + AddrDepth'(1);
      cnt_d    = (push_i && !full_o) ? cnt_q : cnt_q - (AddrDepth+1)'(1);
    end

    // Fall-through bypass: an entry pushed into an empty FIFO is visible at once.
    if (FALL_THROUGH && cnt_zero && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
      end
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/reqrsp_bank_tracker.sv
// Forwards bank requests and routes in-order bank responses back to the issuing crossbar input.
// Zero latency both ways; non-posted requests stall when MaxOutstanding are in flight.
module reqrsp_bank_tracker
  import reqrsp_xbar_pkg::*;
#(
  parameter int unsigned  NumInp          = 32'd0,
  parameter int unsigned  MaxOutstanding  = 32'd4,
  parameter type          tcdm_req_chan_t = logic,
  parameter type          tcdm_rsp_chan_t = logic,
  localparam int unsigned IdxW            = idx_width(NumInp),
  parameter type          mst_sel_t       = logic [IdxW-1:0],
  localparam int unsigned CntW            = $clog2(MaxOutstanding + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  tcdm_req_chan_t xbar_req_i,
  input  mst_sel_t       xbar_req_idx_i,
  input  logic           xbar_req_no_rsp_i,
  input  logic           xbar_req_valid_i,
  output logic           xbar_req_ready_o,
  output tcdm_req_chan_t bank_req_o,
  output logic           bank_req_valid_o,
  input  logic           bank_req_ready_i,
  input  tcdm_rsp_chan_t bank_rsp_i,
  input  logic           bank_rsp_valid_i,
  output logic           bank_rsp_ready_o,
  output tcdm_rsp_chan_t xbar_rsp_o,
  output mst_sel_t       xbar_rsp_sel_o,
  output logic           xbar_rsp_valid_o,
  input  logic           xbar_rsp_ready_i,
  output logic [CntW-1:0] outstanding_o,
  output logic           err_o
);

  localparam int unsigned AddrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic             full, empty, block, push, pop;
  logic [AddrW-1:0] usage;
  mst_sel_t         head_idx;
  logic             err_q, err_d;

  // Full blocks only on the fifo's own flag, never on a same-cycle pop, so
  // the response ready path stays out of the request ready path.
  assign block            = full & ~xbar_req_no_rsp_i;
  assign bank_req_o       = xbar_req_i;
  assign bank_req_valid_o = xbar_req_valid_i & ~block;
  assign xbar_req_ready_o = bank_req_ready_i & ~block;
  assign push             = xbar_req_valid_i & xbar_req_ready_o & ~xbar_req_no_rsp_i;

  assign xbar_rsp_o       = bank_rsp_valid_i ? bank_rsp_i : '0;
  assign xbar_rsp_sel_o   = empty ? '0 : head_idx;
  assign xbar_rsp_valid_o = bank_rsp_valid_i & ~empty;
  assign bank_rsp_ready_o = empty ? 1'b1 : xbar_rsp_ready_i;
  assign pop              = bank_rsp_valid_i & xbar_rsp_ready_i & ~empty;

  assign outstanding_o = full ? CntW'(MaxOutstanding) : CntW'(usage);

  always_comb begin
    err_d = err_q;
    if (bank_rsp_valid_i && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxW),
    .DEPTH        (MaxOutstanding),
    .dtype        (mst_sel_t)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage),
    .data_i  (xbar_req_idx_i),
    .push_i  (push),
    .data_o  (head_idx),
    .pop_i   (pop)
  );

endmodule

// File: tb/tb_reqrsp_bank_tracker.sv
// Scoreboarded bench: expected response selects are queued at request issue and checked on return.
module tb_reqrsp_bank_tracker;

  localparam int unsigned NumInp = 8;
  localparam int unsigned MaxOut = 4;
  typedef logic [31:0] data_t;
  typedef logic [2:0]  mst_sel_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  data_t      xbar_req_i;
  mst_sel_t   xbar_req_idx_i;
  logic       xbar_req_no_rsp_i, xbar_req_valid_i, xbar_req_ready_o;
  data_t      bank_req_o;
  logic       bank_req_valid_o, bank_req_ready_i;
  data_t      bank_rsp_i;
  logic       bank_rsp_valid_i, bank_rsp_ready_o;
  data_t      xbar_rsp_o;
  mst_sel_t   xbar_rsp_sel_o;
  logic       xbar_rsp_valid_o, xbar_rsp_ready_i;
  logic [2:0] outstanding_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;
  mst_sel_t sel_q[$];

  always #5 clk_i = ~clk_i;

  reqrsp_bank_tracker #(
    .NumInp          (NumInp),
    .MaxOutstanding  (MaxOut),
    .tcdm_req_chan_t (data_t),
    .tcdm_rsp_chan_t (data_t)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .xbar_req_i        (xbar_req_i),
    .xbar_req_idx_i    (xbar_req_idx_i),
    .xbar_req_no_rsp_i (xbar_req_no_rsp_i),
    .xbar_req_valid_i  (xbar_req_valid_i),
    .xbar_req_ready_o  (xbar_req_ready_o),
    .bank_req_o        (bank_req_o),
    .bank_req_valid_o  (bank_req_valid_o),
    .bank_req_ready_i  (bank_req_ready_i),
    .bank_rsp_i        (bank_rsp_i),
    .bank_rsp_valid_i  (bank_rsp_valid_i),
    .bank_rsp_ready_o  (bank_rsp_ready_o),
    .xbar_rsp_o        (xbar_rsp_o),
    .xbar_rsp_sel_o    (xbar_rsp_sel_o),
    .xbar_rsp_valid_o  (xbar_rsp_valid_o),
    .xbar_rsp_ready_i  (xbar_rsp_ready_i),
    .outstanding_o     (outstanding_o),
    .err_o             (err_o)
  );

  task automatic idle();
    xbar_req_i = '0; xbar_req_idx_i = '0; xbar_req_no_rsp_i = 1'b0; xbar_req_valid_i = 1'b0;
    bank_req_ready_i = 1'b0; bank_rsp_i = '0; bank_rsp_valid_i = 1'b0; xbar_rsp_ready_i = 1'b0;
  endtask

  // One request beat; the model decides acceptance and records the expected select.
  task automatic send_req(input mst_sel_t idx, input logic no_rsp, output logic got_rdy,
                          output logic exp_rdy, output logic got_bvld, output data_t got_bdat,
                          output data_t sent);
    @(negedge clk_i);
    sent = $urandom;
    xbar_req_i = sent; xbar_req_idx_i = idx; xbar_req_no_rsp_i = no_rsp;
    xbar_req_valid_i = 1'b1; bank_req_ready_i = 1'b1;
    #1;
    got_rdy = xbar_req_ready_o; got_bvld = bank_req_valid_o; got_bdat = bank_req_o;
    exp_rdy = no_rsp || (sel_q.size() < int'(MaxOut));
    if (exp_rdy && !no_rsp) sel_q.push_back(idx);
    @(posedge clk_i); #1;
    idle();
  endtask

  // One response beat with crossbar ready high; pops the expected select.
  task automatic rsp_beat(input data_t d, output logic vld, output mst_sel_t sel,
                          output data_t dat, output mst_sel_t exp_sel);
    @(negedge clk_i);
    bank_rsp_i = d; bank_rsp_valid_i = 1'b1; xbar_rsp_ready_i = 1'b1;
    #1;
    vld = xbar_rsp_valid_o; sel = xbar_rsp_sel_o; dat = xbar_rsp_o;
    exp_sel = (sel_q.size() > 0) ? sel_q.pop_front() : '0;
    @(posedge clk_i); #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
    n_checks++;
    if (xbar_rsp_valid_o !== 1'b0 || bank_req_valid_o !== 1'b0 || bank_rsp_ready_o !== 1'b1)
      begin n_fail++; $display("FAIL reset_outputs rsp_vld=%b req_vld=%b rsp_rdy=%b exp 0/0/1",
                               xbar_rsp_valid_o, bank_req_valid_o, bank_rsp_ready_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    logic r, er, bv, v; data_t bd, s, dd; mst_sel_t sl, es;
    send_req(3'd5, 1'b0, r, er, bv, bd, s);
    n_checks++;
    if (r !== er || bv !== 1'b1 || bd !== s) begin n_fail++; $display("FAIL single_req rdy=%b exp=%b bvld=%b data=%h exp=%h", r, er, bv, bd, s); end
    n_checks++;
    if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL single_outstanding1 got=%0d exp=1", outstanding_o); end
    rsp_beat(32'hCAFE_0005, v, sl, dd, es);
    n_checks++;
    if (v !== 1'b1 || sl !== es || sl !== 3'd5 || dd !== 32'hCAFE_0005)
      begin n_fail++; $display("FAIL single_rsp vld=%b sel=%0d exp=%0d data=%h", v, sl, es, dd); end
    n_checks++;
    if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL single_outstanding0 got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_fill();
    logic r, er, bv, v; data_t bd, s, dd; mst_sel_t sl, es;
    for (int i = 1; i <= 4; i++) begin
      send_req(mst_sel_t'(i), 1'b0, r, er, bv, bd, s);
      n_checks++;
      if (r !== er) begin n_fail++; $display("FAIL fill_accept%0d rdy=%b exp=%b", i, r, er); end
    end
    n_checks++;
    if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL fill_outstanding got=%0d exp=4", outstanding_o); end
    send_req(3'd6, 1'b0, r, er, bv, bd, s);
    n_checks++;
    if (r !== er || r !== 1'b0 || bv !== 1'b0) begin n_fail++; $display("FAIL fill_block rdy=%b bvld=%b exp 0/0", r, bv); end
    send_req(3'd6, 1'b1, r, er, bv, bd, s);
    n_checks++;
    if (r !== 1'b1 || bv !== 1'b1 || bd !== s) begin n_fail++; $display("FAIL fill_posted rdy=%b bvld=%b data=%h exp 1/1/%h", r, bv, bd, s); end
    n_checks++;
    if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL fill_posted_count got=%0d exp=4", outstanding_o); end
    for (int i = 1; i <= 4; i++) begin
      rsp_beat(data_t'(i), v, sl, dd, es);
      n_checks++;
      if (v !== 1'b1 || sl !== es) begin n_fail++; $display("FAIL fill_drain%0d vld=%b sel=%0d exp=%0d", i, v, sl, es); end
    end
  endtask

  task automatic test_order();
    logic r, er, bv, v; data_t bd, s, dd; mst_sel_t sl, es;
    mst_sel_t ids[3];
    ids[0] = 3'd7; ids[1] = 3'd0; ids[2] = 3'd3;
    for (int i = 0; i < 3; i++) send_req(ids[i], 1'b0, r, er, bv, bd, s);
    n_checks++;
    if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL order_count got=%0d exp=3", outstanding_o); end
    for (int i = 0; i < 3; i++) begin
      rsp_beat(data_t'(100 + i), v, sl, dd, es);
      n_checks++;
      if (v !== 1'b1 || sl !== es || sl !== ids[i]) begin n_fail++; $display("FAIL order_sel%0d sel=%0d exp=%0d", i, sl, ids[i]); end
      n_checks++;
      if (outstanding_o !== 3'(2 - i)) begin n_fail++; $display("FAIL order_count%0d got=%0d exp=%0d", i, outstanding_o, 2 - i); end
    end
  endtask

  task automatic test_simul_push_pop();
    logic r, er, bv, v; data_t bd, s, dd; mst_sel_t sl, es;
    send_req(3'd2, 1'b0, r, er, bv, bd, s);
    send_req(3'd5, 1'b0, r, er, bv, bd, s);
    @(negedge clk_i);
    xbar_req_i = 32'h66; xbar_req_idx_i = 3'd6; xbar_req_valid_i = 1'b1; bank_req_ready_i = 1'b1;
    bank_rsp_i = 32'h22; bank_rsp_valid_i = 1'b1; xbar_rsp_ready_i = 1'b1;
    #1;
    n_checks++;
    if (xbar_req_ready_o !== 1'b1 || xbar_rsp_valid_o !== 1'b1 || xbar_rsp_sel_o !== sel_q[0])
      begin n_fail++; $display("FAIL simul_beat rdy=%b vld=%b sel=%0d exp 1/1/%0d", xbar_req_ready_o, xbar_rsp_valid_o, xbar_rsp_sel_o, sel_q[0]); end
    void'(sel_q.pop_front());
    sel_q.push_back(3'd6);
    @(posedge clk_i); #1;
    idle();
    n_checks++;
    if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL simul_count got=%0d exp=2", outstanding_o); end
    for (int i = 0; i < 2; i++) begin
      rsp_beat(data_t'(i), v, sl, dd, es);
      n_checks++;
      if (v !== 1'b1 || sl !== es) begin n_fail++; $display("FAIL simul_drain%0d sel=%0d exp=%0d", i, sl, es); end
    end
  endtask

  task automatic test_backpressure();
    logic r, er, bv, v; data_t bd, s, dd; mst_sel_t sl, es;
    send_req(3'd3, 1'b0, r, er, bv, bd, s);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      bank_rsp_i = 32'hB0B0_0003; bank_rsp_valid_i = 1'b1; xbar_rsp_ready_i = 1'b0;
      #1;
      n_checks++;
      if (bank_rsp_ready_o !== 1'b0 || xbar_rsp_valid_o !== 1'b1 || xbar_rsp_sel_o !== 3'd3 || xbar_rsp_o !== 32'hB0B0_0003)
        begin n_fail++; $display("FAIL bp_hold%0d rdy=%b vld=%b sel=%0d data=%h", c, bank_rsp_ready_o, xbar_rsp_valid_o, xbar_rsp_sel_o, xbar_rsp_o); end
      @(posedge clk_i); #1;
      n_checks++;
      if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL bp_count%0d got=%0d exp=1", c, outstanding_o); end
    end
    rsp_beat(32'hB0B0_0003, v, sl, dd, es);
    n_checks++;
    if (v !== 1'b1 || sl !== es || outstanding_o !== 3'd0) begin n_fail++; $display("FAIL bp_release sel=%0d exp=%0d count=%0d", sl, es, outstanding_o); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 80; c++) begin
      logic rv, nr, br, sv, sr, er;
      mst_sel_t ix; data_t sd;
      @(negedge clk_i);
      rv = 1'($urandom_range(0, 1)); nr = ($urandom_range(0, 3) == 0); br = ($urandom_range(0, 3) != 0);
      ix = mst_sel_t'($urandom); sd = $urandom;
      sv = (sel_q.size() > 0) && ($urandom_range(0, 1) == 1);
      sr = 1'($urandom_range(0, 1));
      xbar_req_i = $urandom; xbar_req_idx_i = ix; xbar_req_no_rsp_i = nr; xbar_req_valid_i = rv;
      bank_req_ready_i = br; bank_rsp_i = sd; bank_rsp_valid_i = sv; xbar_rsp_ready_i = sr;
      #1;
      er = br && (nr || sel_q.size() < int'(MaxOut));
      n_checks++;
      if (xbar_req_ready_o !== er) begin n_fail++; $display("FAIL b2b_req_ready c=%0d got=%b exp=%b", c, xbar_req_ready_o, er); end
      if (sv) begin
        n_checks++;
        if (xbar_rsp_valid_o !== 1'b1 || xbar_rsp_sel_o !== sel_q[0] || xbar_rsp_o !== sd || bank_rsp_ready_o !== sr)
          begin n_fail++; $display("FAIL b2b_rsp c=%0d vld=%b sel=%0d exp=%0d data=%h exp=%h", c, xbar_rsp_valid_o, xbar_rsp_sel_o, sel_q[0], xbar_rsp_o, sd); end
        if (sr) void'(sel_q.pop_front());
      end
      if (rv && er && !nr) sel_q.push_back(ix);
      @(posedge clk_i); #1;
      n_checks++;
      if (outstanding_o !== 3'(sel_q.size())) begin n_fail++; $display("FAIL b2b_count c=%0d got=%0d exp=%0d", c, outstanding_o, sel_q.size()); end
    end
    idle();
    while (sel_q.size() > 0) begin
      logic v; data_t dd; mst_sel_t sl, es;
      rsp_beat(32'h5A5A, v, sl, dd, es);
      n_checks++;
      if (v !== 1'b1 || sl !== es) begin n_fail++; $display("FAIL b2b_drain sel=%0d exp=%0d", sl, es); end
    end
  endtask

  task automatic test_spurious();
    @(negedge clk_i);
    bank_rsp_i = 32'hDEAD; bank_rsp_valid_i = 1'b1; xbar_rsp_ready_i = 1'b0;
    #1;
    n_checks++;
    if (bank_rsp_ready_o !== 1'b1 || xbar_rsp_valid_o !== 1'b0 || err_o !== 1'b0)
      begin n_fail++; $display("FAIL spur_beat rdy=%b vld=%b err=%b exp 1/0/0", bank_rsp_ready_o, xbar_rsp_valid_o, err_o); end
    @(posedge clk_i); #1;
    idle();
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL spur_err_set got=%b exp=1", err_o); end
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_reset_mid();
    logic r, er, bv; data_t bd, s;
    send_req(3'd1, 1'b0, r, er, bv, bd, s);
    send_req(3'd4, 1'b0, r, er, bv, bd, s);
    n_checks++;
    if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL rmid_pre_count got=%0d exp=2", outstanding_o); end
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    sel_q.delete();
    n_checks++;
    if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_async count=%0d err=%b exp 0/0", outstanding_o, err_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bank_rsp_i = 32'h1; bank_rsp_valid_i = 1'b1; xbar_rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    idle();
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL rmid_late_rsp err=%b exp=1", err_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fill();
    test_order();
    test_simul_push_pop();
    test_backpressure();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reqrsp_bank_tracker.md
Name: reqrsp_bank_tracker

Overview:
- Sits between one output port of the cache-bank crossbar and one cache bank.
- Forwards bank requests unchanged and records, in issue order, which crossbar input each request came from.
- Drives that recorded index as the response-path select for the crossbar, so in-order bank responses return to the correct core port.
- Bounds the outstanding request count per bank and flags protocol violations.

Parameters:
- NumInp, 32'd0, number of crossbar inputs (> 0); sets the source index width.
- MaxOutstanding, 32'd4, maximum responses in flight per bank (>= 1, power of two not required).
- tcdm_req_chan_t, logic, request payload type.
- tcdm_rsp_chan_t, logic, response payload type.
- mst_sel_t, logic[IdxW-1:0], source index type; IdxW = (NumInp>1) ? $clog2(NumInp) : 1.

Ports:
- clk_i  in  1  clock, positive edge triggered
- rst_ni  in  1  asynchronous active-low reset
- xbar_req_i  in  tcdm_req_chan_t  request from crossbar output
- xbar_req_idx_i  in  mst_sel_t  crossbar input that won arbitration for this request
- xbar_req_no_rsp_i  in  1  request produces no bank response (posted write)
- xbar_req_valid_i  in  1  request valid
- xbar_req_ready_o  out  1  request ready
- bank_req_o  out  tcdm_req_chan_t  request to bank
- bank_req_valid_o  out  1  request valid to bank
- bank_req_ready_i  in  1  bank ready
- bank_rsp_i  in  tcdm_rsp_chan_t  bank response
- bank_rsp_valid_i  in  1  bank response valid
- bank_rsp_ready_o  out  1  bank response ready
- xbar_rsp_o  out  tcdm_rsp_chan_t  response to crossbar
- xbar_rsp_sel_o  out  mst_sel_t  crossbar input the response is routed to
- xbar_rsp_valid_o  out  1  response valid to crossbar
- xbar_rsp_ready_i  in  1  crossbar ready
- outstanding_o  out  $clog2(MaxOutstanding+1)  number of responses in flight
- err_o  out  1  sticky error: response arrived with no recorded request

Behaviour:
- Reset (asynchronous, rst_ni low): index FIFO empty, outstanding_o=0, err_o=0.
  - All valid outputs are combinational from inputs and state, so they are 0 while inputs are idle.
- Request path (zero latency, combinational):
  - bank_req_o = xbar_req_i.
  - bank_req_valid_o = xbar_req_valid_i & ~block.
  - xbar_req_ready_o = bank_req_ready_i & ~block.
  - block = full & ~xbar_req_no_rsp_i.
  - full = (count == MaxOutstanding).
  - A full FIFO never accepts a push, even if a pop occurs in the same cycle. This keeps the response ready path off the request ready path.
- Push: on request handshake (valid & ready) with xbar_req_no_rsp_i=0, push xbar_req_idx_i; count+1.
  - Posted requests (no_rsp=1) are forwarded but never pushed, and are never blocked by full.
- Response path (zero latency):
  - xbar_rsp_o = bank_rsp_i when valid, else '0.
  - xbar_rsp_sel_o = FIFO head when non-empty, else '0.
  - xbar_rsp_valid_o = bank_rsp_valid_i & ~empty.
  - bank_rsp_ready_o = empty ? 1 : xbar_rsp_ready_i.
- Pop: on response handshake with FIFO non-empty; count-1.
- Simultaneous push and pop (count < MaxOutstanding): count unchanged; head advances and the new entry is written at the tail.
- Empty with bank_rsp_valid_i=1: the response is consumed and dropped (ready=1, xbar_rsp_valid_o=0), and err_o is set. err_o clears only on reset.
- Wrap-around: read and write pointers wrap modulo MaxOutstanding independently; count disambiguates full from empty.
- Responses are in order; the bank guarantees one response per non-posted request, in issue order.
- Reset mid-operation: all in-flight entries are discarded. Later bank responses for them set err_o, and the bank is reset together with this block.
- Holding: if bank_req_ready_i drops, xbar_req_ready_o drops with it, so the upstream valid/data hold rule is preserved.

Decomposition:
- Shared package reqrsp_xbar_pkg holds:
  - the function idx_width(n) returning (n>1) ? $clog2(n) : 1;
  - the tracker error-code enum used by the cluster status register.
- Single sub-module: the codebase fifo_v3 instance (FALL_THROUGH=0, DEPTH=MaxOutstanding, dtype=mst_sel_t) stores indices.
- count comes from fifo_v3 usage plus the full flag; no separate counter is needed.

Test Plan:
- Single read: idx=5, no_rsp=0, handshake; bank response 1 cycle later -> xbar_rsp_valid_o=1, xbar_rsp_sel_o=5, outstanding_o 1->0.
- Fill (MaxOutstanding=4): issue idx 1,2,3,4 with no responses -> 5th non-posted request sees xbar_req_ready_o=0. A posted request (no_rsp=1) in the same state still passes.
- Order: issue idx 7,0,3, then respond 3 times with xbar_rsp_ready_i=1 -> sel sequence 7,0,3; outstanding_o 3,2,1,0.
- Simultaneous push/pop at count=2: push idx 6 while popping -> count stays 2, and the next two sels are the older entry then 6.
- Backpressure: xbar_rsp_ready_i=0 for 3 cycles with bank_rsp_valid_i=1 -> bank_rsp_ready_o=0; sel and data stable; no pop until ready.
- Spurious response while empty -> bank_rsp_ready_o=1, xbar_rsp_valid_o=0, err_o=1 from next cycle and staying high; an asynchronous reset mid-burst clears err_o and outstanding_o to 0 immediately.
